ahb_bus_arbiter: RTL and testbench

- Shares the single-slave AHB register interface among `NUM_MASTERS` requesters, using round-robin arbitration with locked-transfer support.
- Owns the grant state, the address/control multiplexer and the one-phase-delayed write-data multiplexer.
- Sits between the masters and the slave's `hsel_x`/`haddr`/`htrans`/`hsize`/`hwrite`/`hwdata` inputs.
- Slave `hready_out` is fed back as `hready`.

---
 rtl/ahb_bus_arbiter.sv | 97 +++++++++
 tb/tb_ahb_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with locked-transfer retention. Muxes one master's
// address/control to the single slave, and delays the write-data select by one hready phase.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                       hclk,
  input  logic                       hreset_n,
  input  logic                       hready,
  input  logic [NUM_MASTERS-1:0]     hbusreq,
  input  logic [NUM_MASTERS-1:0]     hlock,
  input  logic [3*NUM_MASTERS-1:0]   m_haddr,
  input  logic [2*NUM_MASTERS-1:0]   m_htrans,
  input  logic [3*NUM_MASTERS-1:0]   m_hsize,
  input  logic [NUM_MASTERS-1:0]     m_hwrite,
  input  logic [8*NUM_MASTERS-1:0]   m_hwdata,
  output logic [NUM_MASTERS-1:0]     hgrant,
  output logic [MW-1:0]              hmaster,
  output logic                       hmastlock,
  output logic [2:0]                 haddr,
  output logic [1:0]                 htrans,
  output logic [2:0]                 hsize,
  output logic                       hwrite,
  output logic [7:0]                 hwdata
);

  logic [MW-1:0]          hmaster_d;
  logic [MW-1:0]          next_master;
  logic                   next_lock;
  logic [NUM_MASTERS-1:0] next_grant;
  logic                   found;
  int                     idx;

  // The current owner doubles as the round-robin pointer: scanning starts one past it
  // and ends with the owner itself. With no requests, the grant parks on master 0.
  always_comb begin
    next_master = '0;
    next_lock   = 1'b0;
    found       = 1'b0;
    idx         = 0;
    if (hlock[hmaster] && hbusreq[hmaster]) begin
      next_master = hmaster;
      next_lock   = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        idx = (int'(hmaster) + k) % NUM_MASTERS;
        if (!found && hbusreq[idx]) begin
          found       = 1'b1;
          next_master = MW'(idx);
          next_lock   = hlock[idx];
        end
      end
    end
  end

  always_comb begin
    next_grant = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      next_grant[i] = (next_master == MW'(i));
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      hgrant    <= NUM_MASTERS'(1);
      hmaster   <= '0;
      hmastlock <= 1'b0;
      hmaster_d <= '0;
    end else if (hready) begin
      hgrant    <= next_grant;
      hmaster   <= next_master;
      hmastlock <= next_lock;
      hmaster_d <= hmaster;
    end
  end

  // Address/control follow the address-phase owner; write data follows the data-phase owner.
  always_comb begin
    haddr  = m_haddr[2:0];
    htrans = m_htrans[1:0];
    hsize  = m_hsize[2:0];
    hwrite = m_hwrite[0];
    hwdata = m_hwdata[7:0];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hmaster == MW'(i)) begin
        haddr  = m_haddr[3*i +: 3];
        htrans = m_htrans[2*i +: 2];
        hsize  = m_hsize[3*i +: 3];
        hwrite = m_hwrite[i];
      end
      if (hmaster_d == MW'(i)) begin
        hwdata = m_hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scoreboard bench for ahb_bus_arbiter with two masters.
// Expectations are queued alongside each stimulus step and checked after the following edge.
module tb_ahb_bus_arbiter;

  localparam int N  = 2;
  localparam int MW = 1;

  logic             hclk = 1'b0;
  logic             hreset_n;
  logic             hready;
  logic [N-1:0]     hbusreq;
  logic [N-1:0]     hlock;
  logic [3*N-1:0]   m_haddr;
  logic [2*N-1:0]   m_htrans;
  logic [3*N-1:0]   m_hsize;
  logic [N-1:0]     m_hwrite;
  logic [8*N-1:0]   m_hwdata;
  logic [N-1:0]     hgrant;
  logic [MW-1:0]    hmaster;
  logic             hmastlock;
  logic [2:0]       haddr;
  logic [1:0]       htrans;
  logic [2:0]       hsize;
  logic             hwrite;
  logic [7:0]       hwdata;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MW(MW)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hready(hready),
    .hbusreq(hbusreq), .hlock(hlock),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hsize(m_hsize),
    .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock),
    .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
    .hwdata(hwdata)
  );

  // Kinds: 0 hgrant, 1 hmaster, 2 hmastlock, 3 haddr, 4 hwdata, 5 one-hot, 6 htrans
  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] value;
  } exp_t;

  exp_t sb[$];
  int   assertions_evaluated = 0;
  int   failures = 0;

  function automatic logic [7:0] observe(int kind);
    case (kind)
      0:       return 8'(hgrant);
      1:       return 8'(hmaster);
      2:       return 8'(hmastlock);
      3:       return 8'(haddr);
      4:       return hwdata;
      5:       return 8'($onehot(hgrant));
      default: return 8'(htrans);
    endcase
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic rdy,
                               input logic [N-1:0] req, input logic [N-1:0] lck);
    hreset_n = rst_n;
    hready   = rdy;
    hbusreq  = req;
    hlock    = lck;
  endtask

  task automatic expectOut(input string tag, input int kind, input logic [7:0] value);
    exp_t e;
    e.tag   = tag;
    e.kind  = kind;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic expectOwner(input string tag, input logic [7:0] grant,
                             input logic [7:0] master, input logic [7:0] lock);
    expectOut({tag, "_hgrant"}, 0, grant);
    expectOut({tag, "_hmaster"}, 1, master);
    expectOut({tag, "_hmastlock"}, 2, lock);
    expectOut({tag, "_onehot"}, 5, 8'd1);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      assertions_evaluated++;
      assert (obs === e.value) else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
      end
    end
  endtask

  initial begin
    m_haddr  = {3'd5, 3'd6};
    m_htrans = {2'b11, 2'b10};
    m_hsize  = '0;
    m_hwrite = 2'b11;
    m_hwdata = {8'h22, 8'h11};

    // Reset held two cycles with every master requesting
    applyStimulus(1'b0, 1'b1, 2'b11, 2'b00);
    tick();
    expectOwner("reset", 8'b01, 8'd0, 8'd0);
    expectOut("reset_hwdata", 4, 8'h11);
    tick();
    checkOutput();

    // First edge after release hands over to master 1, then alternation
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b00);
    expectOwner("rr0", 8'b10, 8'd1, 8'd0);
    tick();
    checkOutput();
    for (int i = 1; i < 6; i++) begin
      expectOwner($sformatf("rr%0d", i), (i % 2 == 1) ? 8'b01 : 8'b10,
                  8'((i + 1) % 2), 8'd0);
      tick();
      checkOutput();
    end

    // Give master 1 the bus, then stall with master 0 requesting
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b00);
    expectOwner("ws_own", 8'b10, 8'd1, 8'd0);
    tick();
    checkOutput();
    applyStimulus(1'b1, 1'b0, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++) begin
      expectOwner($sformatf("ws_hold%0d", i), 8'b10, 8'd1, 8'd0);
      expectOut($sformatf("ws_hwdata%0d", i), 4, 8'h11);
      tick();
      checkOutput();
    end
    applyStimulus(1'b1, 1'b1, 2'b01, 2'b00);
    expectOwner("ws_release", 8'b01, 8'd0, 8'd0);
    expectOut("ws_hwdata_m1", 4, 8'h22);
    tick();
    checkOutput();

    // Master 0 locked for four arbitration points against master 1
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b01);
    for (int i = 0; i < 4; i++) begin
      expectOwner($sformatf("lock%0d", i), 8'b01, 8'd0, 8'd1);
      tick();
      checkOutput();
    end
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b00);
    expectOwner("unlock", 8'b10, 8'd1, 8'd0);
    tick();
    checkOutput();

    // No requests: park on master 0
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00);
    expectOwner("park", 8'b01, 8'd0, 8'd0);
    tick();
    checkOutput();

    // Back-to-back writes: address on consecutive cycles, data one cycle later each
    m_haddr  = {3'd1, 3'd2};
    m_hwdata = {8'h3C, 8'hA5};
    applyStimulus(1'b1, 1'b1, 2'b01, 2'b00);
    expectOut("da_haddr_m0", 3, 8'd2);
    expectOut("da_htrans_m0", 6, 8'd2);
    tick();
    checkOutput();
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b00);
    expectOut("da_haddr_m1", 3, 8'd1);
    expectOut("da_htrans_m1", 6, 8'd3);
    expectOut("da_hwdata_m0", 4, 8'hA5);
    tick();
    checkOutput();
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00);
    expectOut("da_hwdata_m1", 4, 8'h3C);
    expectOut("da_haddr_park", 3, 8'd2);
    tick();
    checkOutput();

    // Reset while master 1 owns discards ownership at once
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b00);
    expectOwner("pre_rst", 8'b10, 8'd1, 8'd0);
    tick();
    checkOutput();
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b10, 2'b00);
    expectOwner("mid_rst", 8'b01, 8'd0, 8'd0);
    expectOut("mid_rst_hwdata", 4, 8'hA5);
    tick();
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions_evaluated, failures);
    $finish;
  end

endmodule
